// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges over a win_len-cycle gate window.
// Define FREQ_METER_SYNC_EN to add a 2-flop synchronizer in front of edge detect.
module freq_meter #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_out,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  state_t r_state, w_next;
  logic [WIN_W-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic r_ovf, r_samp, r_prev, w_edge;
`ifdef FREQ_METER_SYNC_EN
  logic r_meta;
  always_ff @(posedge clk) begin
    r_meta <= rst ? 1'b0 : sig_in;
    r_samp <= rst ? 1'b0 : r_meta;
  end
`else
  always_ff @(posedge clk) r_samp <= rst ? 1'b0 : sig_in;
`endif
  assign w_edge = r_samp & ~r_prev;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)
      w_next = start ? (win_len == '0 ? DONE : MEASURE) : IDLE;
    else if (r_state == MEASURE)
      w_next = r_rem == WIN_W'(1) ? DONE : MEASURE;
    else if (r_state == DONE)
      w_next = cnt_ready ? IDLE : DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_prev  <= 1'b0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_prev  <= r_samp;
      if (r_state == IDLE && start) begin
        r_rem <= win_len;
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (r_state == MEASURE) begin
        r_rem <= r_rem - 1'b1;
        // saturate instead of wrapping; the overflow flag records the lost edges
        if (w_edge && &r_cnt) r_ovf <= 1'b1;
        else if (w_edge) r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign busy      = r_state != IDLE;
  assign cnt_valid = r_state == DONE;
  assign cnt_out   = r_cnt;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized check of freq_meter (CNT_W 16 and 4) against a sampled-history edge model.
module tb_freq_meter;
  logic clk = 0, rst = 1, sig_in = 0, start = 0, cnt_ready = 0;
  logic [15:0] win_len = 0;
  logic busy, cnt_valid, ovf, busy4, cnt_valid4, ovf4;
  logic [15:0] cnt_out;
  logic [3:0] cnt_out4;
  int checks = 0, errors = 0;
  int cyc = 0;
  int mode = 4;
  bit h [0:99999];
`ifdef FREQ_METER_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif
  always #5 clk = ~clk;
  freq_meter dut (.clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .win_len(win_len),
    .busy(busy), .cnt_out(cnt_out), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready), .ovf(ovf));
  freq_meter #(.CNT_W(4)) dut4 (.clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .win_len(win_len),
    .busy(busy4), .cnt_out(cnt_out4), .cnt_valid(cnt_valid4), .cnt_ready(cnt_ready), .ovf(ovf4));
  // h[e] is the sig_in level seen at clock edge e; mode 0 is random, otherwise a square wave of that period
  always @(posedge clk) begin
    h[cyc] = sig_in;
    cyc++;
    #1 sig_in = mode == 0 ? 1'($urandom % 2) : ((cyc % mode) < mode / 2);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic measure(input int w, input int exp_cnt, input int hold);
    int k, n, cnt, c16, c4;
    bit o16, o4;
    start = 1;
    win_len = 16'(w);
    @(posedge clk); #1;
    start = 0;
    k = cyc - 1;
    n = 0;
    while (!cnt_valid && n < w + 10) begin
      if (n == w / 2) begin start = 1; win_len = 3; end
      @(posedge clk); #1;
      start = 0;
      n++;
    end
    chk("latency", n, w);
    cnt = 0;
    for (int j = k + 1; j <= k + w; j++)
      if (j - L - 1 >= 0 && h[j - L] && !h[j - L - 1]) cnt++;
    c16 = cnt > 65535 ? 65535 : cnt;
    o16 = cnt > 65535;
    c4 = cnt > 15 ? 15 : cnt;
    o4 = cnt > 15;
    chk("cnt", cnt_out, c16);
    chk("ovf", ovf, o16);
    chk("cnt4", cnt_out4, c4);
    chk("ovf4", ovf4, o4);
    chk("busy_done", {busy, busy4, cnt_valid4}, 3'b111);
    if (exp_cnt >= 0) chk("spec_cnt", cnt_out, exp_cnt);
    repeat (hold) begin
      start = 1'($urandom % 2);
      win_len = 16'($urandom);
      @(posedge clk); #1;
      start = 0;
      chk("hold", {busy, cnt_valid, ovf, cnt_out, cnt_valid4, ovf4, cnt_out4},
          {1'b1, 1'b1, o16, 16'(c16), 1'b1, o4, 4'(c4)});
    end
    cnt_ready = 1;
    start = 1;
    win_len = 5;
    @(posedge clk); #1;
    cnt_ready = 0;
    start = 0;
    chk("release", {busy, cnt_valid, busy4, cnt_valid4}, 4'b0);
    @(posedge clk); #1;
    chk("idle", {busy, busy4}, 2'b0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {busy, cnt_valid, ovf, cnt_out, busy4, cnt_valid4, ovf4, cnt_out4}, 0);
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    mode = 4;  measure(100, 25, 2);
    mode = 10; measure(100, 10, 1);
    mode = 2;  measure(100, 50, 1);
    mode = 4;  measure(0, 0, 20);
    start = 1;
    win_len = 100;
    @(posedge clk); #1;
    start = 0;
    repeat (50) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("abort", {busy, cnt_valid, ovf, cnt_out, busy4, cnt_valid4, ovf4, cnt_out4}, 0);
    rst = 0;
    repeat (6) @(posedge clk);
    #1;
    measure(40, 10, 1);
    repeat (12) begin
      case ($urandom_range(0, 4))
        0: mode = 0;
        1: mode = 2;
        2: mode = 4;
        3: mode = 6;
        default: mode = 10;
      endcase
      measure($urandom_range(1, 300), -1, $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
